// File: rtl/hard_mem_1rw_req_ctrl.sv
// rtl/hard_mem_1rw_req_ctrl.sv - 1rw SRAM request controller with a credit-guarded 2-entry read response buffer
// Define HARD_MEM_CLEAR_ON_RESET_EN to zero-fill every SRAM word after reset release.
module hard_mem_1rw_req_ctrl #(
  parameter int width_p = 64,
  parameter int els_p = 512,
  localparam int addr_width_lp = $clog2(els_p),
  localparam int mask_width_lp = width_p >> 3
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     req_v_i,
  output logic                     req_ready_o,
  input  logic                     req_w_i,
  input  logic [addr_width_lp-1:0] req_addr_i,
  input  logic [width_p-1:0]       req_data_i,
  input  logic [mask_width_lp-1:0] req_mask_i,
  output logic                     resp_v_o,
  output logic [width_p-1:0]       resp_data_o,
  input  logic                     resp_yumi_i,
  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  output logic [mask_width_lp-1:0] mem_w_mask_o,
  input  logic [width_p-1:0]       mem_data_i,
  output logic                     init_done_o
);

  localparam logic [0:0] ST_READY = 1'b1;
`ifdef HARD_MEM_CLEAR_ON_RESET_EN
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] RESET_STATE = ST_INIT;
`else
  localparam logic [0:0] RESET_STATE = ST_READY;
`endif

  logic [0:0] state_q, state_d;
  logic [1:0] count_q, count_d;
  logic       inflight_q, inflight_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [width_p-1:0] buf_q [2];

  logic       in_ready;
  logic       pop;
  logic       push;
  logic       accept;
  logic [2:0] credit_used;

  assign in_ready = (state_q == ST_READY);
  assign pop      = resp_yumi_i & resp_v_o;
  assign push     = inflight_q;

  // A same-cycle pop frees a slot, so ready may rise combinationally with yumi.
  assign credit_used = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign req_ready_o = reset_n_i & in_ready & (credit_used < 3'd2);
  assign accept      = req_v_i & req_ready_o;

`ifdef HARD_MEM_CLEAR_ON_RESET_EN
  logic [addr_width_lp-1:0] init_addr_q, init_addr_d;
  logic                     init_last;

  assign init_last   = (init_addr_q == addr_width_lp'(els_p - 1));
  assign init_done_o = in_ready;

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == ST_INIT) begin
      init_addr_d = init_last ? '0 : init_addr_q + addr_width_lp'(1);
      if (init_last) begin
        state_d = ST_READY;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      init_addr_q <= '0;
    end else begin
      init_addr_q <= init_addr_d;
    end
  end
`else
  assign state_d     = state_q;
  assign init_done_o = 1'b1;
`endif

  always_comb begin
    mem_v_o      = accept;
    mem_w_o      = req_w_i;
    mem_addr_o   = req_addr_i;
    mem_data_o   = req_data_i;
    mem_w_mask_o = req_mask_i;
`ifdef HARD_MEM_CLEAR_ON_RESET_EN
    if (state_q == ST_INIT) begin
      mem_v_o      = reset_n_i;
      mem_w_o      = 1'b1;
      mem_addr_o   = init_addr_q;
      mem_data_o   = '0;
      mem_w_mask_o = '1;
    end
`endif
  end

  always_comb begin
    inflight_d = accept & ~req_w_i;
    count_d    = count_q + 2'(push) - 2'(pop);
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= RESET_STATE;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // mem_data_i is only meaningful the cycle after a read, which is exactly when inflight_q is set.
  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_q[wr_ptr_q] <= mem_data_i;
    end
  end

  assign resp_v_o    = (count_q != 2'd0);
  assign resp_data_o = buf_q[rd_ptr_q];

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert ((3'(count_q) + 3'(inflight_q)) <= 3'd2)
        else $error("hard_mem_1rw_req_ctrl: response buffer credit exceeded");
      assert (!(resp_yumi_i && !resp_v_o))
        else $error("hard_mem_1rw_req_ctrl: resp_yumi_i asserted without resp_v_o");
    end
  end
`endif

endmodule

// File: tb/tb_hard_mem_1rw_req_ctrl.sv
// tb/tb_hard_mem_1rw_req_ctrl.sv - directed self-checking bench for hard_mem_1rw_req_ctrl
// Includes the zero-fill scenario when HARD_MEM_CLEAR_ON_RESET_EN is defined.
module tb_hard_mem_1rw_req_ctrl;

  localparam int W  = 64;
  localparam int E  = 512;
  localparam int AW = 9;
  localparam int MW = 8;
`ifdef HARD_MEM_CLEAR_ON_RESET_EN
  localparam logic EXP_INIT_DONE_RST = 1'b0;
`else
  localparam logic EXP_INIT_DONE_RST = 1'b1;
`endif

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          req_v_i;
  logic          req_ready_o;
  logic          req_w_i;
  logic [AW-1:0] req_addr_i;
  logic [W-1:0]  req_data_i;
  logic [MW-1:0] req_mask_i;
  logic          resp_v_o;
  logic [W-1:0]  resp_data_o;
  logic          resp_yumi_i;
  logic          mem_v_o;
  logic          mem_w_o;
  logic [AW-1:0] mem_addr_o;
  logic [W-1:0]  mem_data_o;
  logic [MW-1:0] mem_w_mask_o;
  logic [W-1:0]  mem_data_i;
  logic          init_done_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  hard_mem_1rw_req_ctrl #(.width_p(W), .els_p(E)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_w_i(req_w_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_mask_i(req_mask_i),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_w_mask_o(mem_w_mask_o),
    .mem_data_i(mem_data_i), .init_done_o(init_done_o)
  );

  // Byte-masked 1rw SRAM with one cycle read latency.
  logic [W-1:0] sram [E];
  logic [W-1:0] sram_rd_q;
  always @(posedge clk_i) begin
    if (mem_v_o) begin
      if (mem_w_o) begin
        for (int b = 0; b < MW; b++)
          if (mem_w_mask_o[b]) sram[mem_addr_o][b*8 +: 8] <= mem_data_o[b*8 +: 8];
      end else begin
        sram_rd_q <= sram[mem_addr_o];
      end
    end
  end
  assign mem_data_i = sram_rd_q;

  function automatic logic [W-1:0] sval(input int i);
    return 64'h5EED_0000_0000_0000 | 64'(i);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    req_v_i = 1'b0; req_w_i = 1'b0; req_addr_i = '0; req_data_i = '0; req_mask_i = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [MW-1:0] m);
    req_v_i = 1'b1; req_w_i = 1'b1; req_addr_i = a; req_data_i = d; req_mask_i = m;
    tick();
    idle();
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    req_v_i = 1'b1; req_w_i = 1'b0; req_addr_i = a;
    tick();
    idle();
  endtask

  task automatic pop();
    resp_yumi_i = 1'b1;
    tick();
    resp_yumi_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; resp_yumi_i = 1'b0; idle();
    #1;
    checks++; if (resp_v_o !== 1'b0) begin failures++; $display("FAIL rst_resp_v: got %b expected 0", resp_v_o); end
    checks++; if (mem_v_o !== 1'b0) begin failures++; $display("FAIL rst_mem_v: got %b expected 0", mem_v_o); end
    checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b expected 0", req_ready_o); end
    checks++; if (init_done_o !== EXP_INIT_DONE_RST) begin failures++; $display("FAIL rst_init_done: got %b expected %b", init_done_o, EXP_INIT_DONE_RST); end
    @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    #1;
`ifndef HARD_MEM_CLEAR_ON_RESET_EN
    checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL rel_ready: got %b expected 1", req_ready_o); end
`endif
  endtask

`ifdef HARD_MEM_CLEAR_ON_RESET_EN
  task automatic test_clear();
    int cycles = 0;
    int writes = 0;
    while (init_done_o !== 1'b1 && cycles < 1000) begin
      if (mem_v_o && mem_w_o && mem_w_mask_o == '1 && mem_data_o == '0 && mem_addr_o == cycles[AW-1:0])
        writes++;
      tick();
      cycles++;
    end
    checks++; if (cycles != E) begin failures++; $display("FAIL clear_cycles: got %0d expected %0d", cycles, E); end
    checks++; if (writes != E) begin failures++; $display("FAIL clear_writes: got %0d expected %0d", writes, E); end
    do_read(9'd5);
    tick();
    checks++; if (resp_v_o !== 1'b1 || resp_data_o !== 64'h0) begin failures++; $display("FAIL clear_read5: got v=%b d=%h expected v=1 d=0", resp_v_o, resp_data_o); end
    pop();
  endtask
`endif

  task automatic test_write_read();
    req_v_i = 1'b1; req_w_i = 1'b1; req_addr_i = 9'd3; req_data_i = 64'h1122334455667788; req_mask_i = 8'hFF;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL wr_ready: got %b expected 1", req_ready_o); end
    checks++; if ({mem_v_o, mem_w_o, mem_addr_o, mem_w_mask_o} !== {1'b1, 1'b1, 9'd3, 8'hFF}) begin
      failures++; $display("FAIL wr_mem_ctl: got v=%b w=%b a=%0d m=%h expected v=1 w=1 a=3 m=ff", mem_v_o, mem_w_o, mem_addr_o, mem_w_mask_o); end
    checks++; if (mem_data_o !== 64'h1122334455667788) begin failures++; $display("FAIL wr_mem_data: got %h expected 1122334455667788", mem_data_o); end
    tick();
    req_w_i = 1'b0;
    #1;
    checks++; if (mem_v_o !== 1'b1 || mem_w_o !== 1'b0) begin failures++; $display("FAIL rd_mem_ctl: got v=%b w=%b expected v=1 w=0", mem_v_o, mem_w_o); end
    tick();
    idle();
    #1;
    checks++; if (mem_v_o !== 1'b0) begin failures++; $display("FAIL idle_mem_v: got %b expected 0", mem_v_o); end
    checks++; if (resp_v_o !== 1'b0) begin failures++; $display("FAIL rd_early: got %b expected 0", resp_v_o); end
    tick();
    checks++; if (resp_v_o !== 1'b1 || resp_data_o !== 64'h1122334455667788) begin
      failures++; $display("FAIL rd_resp: got v=%b d=%h expected v=1 d=1122334455667788", resp_v_o, resp_data_o); end
    pop();
    checks++; if (resp_v_o !== 1'b0) begin failures++; $display("FAIL rd_popped: got %b expected 0", resp_v_o); end
  endtask

  task automatic test_mask();
    do_write(9'd9, 64'h0, 8'hFF);
    do_write(9'd9, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    do_read(9'd9);
    tick();
    checks++; if (resp_v_o !== 1'b1 || resp_data_o !== 64'h0000_0000_FFFF_FFFF) begin
      failures++; $display("FAIL mask_resp: got v=%b d=%h expected v=1 d=00000000ffffffff", resp_v_o, resp_data_o); end
    pop();
  endtask

  task automatic test_backpressure();
    do_write(9'd20, 64'hB0B0_0000_0000_0014, 8'hFF);
    do_write(9'd21, 64'hB0B0_0000_0000_0015, 8'hFF);
    do_write(9'd22, 64'hB0B0_0000_0000_0016, 8'hFF);
    req_v_i = 1'b1; req_w_i = 1'b0; req_addr_i = 9'd20;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL bp_ready1: got %b expected 1", req_ready_o); end
    tick();
    req_addr_i = 9'd21;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL bp_ready2: got %b expected 1", req_ready_o); end
    tick();
    req_addr_i = 9'd22;
    #1;
    checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready3: got %b expected 0", req_ready_o); end
    tick();
    checks++; if (req_ready_o !== 1'b0 || mem_v_o !== 1'b0) begin failures++; $display("FAIL bp_stall: got ready=%b mem_v=%b expected 0 0", req_ready_o, mem_v_o); end
    checks++; if (resp_v_o !== 1'b1 || resp_data_o !== 64'hB0B0_0000_0000_0014) begin failures++; $display("FAIL bp_head: got v=%b d=%h expected v=1 d=b0b0000000000014", resp_v_o, resp_data_o); end
    resp_yumi_i = 1'b1;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL bp_ready_pop: got %b expected 1", req_ready_o); end
    tick();
    idle();
    checks++; if (resp_v_o !== 1'b1 || resp_data_o !== 64'hB0B0_0000_0000_0015) begin failures++; $display("FAIL bp_second: got v=%b d=%h expected v=1 d=b0b0000000000015", resp_v_o, resp_data_o); end
    tick();
    checks++; if (resp_v_o !== 1'b1 || resp_data_o !== 64'hB0B0_0000_0000_0016) begin failures++; $display("FAIL bp_third: got v=%b d=%h expected v=1 d=b0b0000000000016", resp_v_o, resp_data_o); end
    tick();
    resp_yumi_i = 1'b0;
    checks++; if (resp_v_o !== 1'b0) begin failures++; $display("FAIL bp_drained: got %b expected 0", resp_v_o); end
  endtask

  task automatic test_streaming();
    logic exp_v;
    for (int i = 0; i < 16; i++) do_write(AW'(i), sval(i), 8'hFF);
    for (int c = 0; c < 19; c++) begin
      req_v_i = (c < 16); req_w_i = 1'b0; req_addr_i = AW'(c);
      resp_yumi_i = resp_v_o;
      #1;
      exp_v = (c >= 2 && c < 18);
      if (c < 16) begin
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL stream_ready c=%0d: got %b expected 1", c, req_ready_o); end
      end
      checks++; if (resp_v_o !== exp_v) begin failures++; $display("FAIL stream_v c=%0d: got %b expected %b", c, resp_v_o, exp_v); end
      if (exp_v) begin
        checks++; if (resp_data_o !== sval(c - 2)) begin failures++; $display("FAIL stream_data c=%0d: got %h expected %h", c, resp_data_o, sval(c - 2)); end
      end
      tick();
    end
    resp_yumi_i = 1'b0;
    idle();
  endtask

  task automatic test_hazard();
    do_write(9'd7, 64'hAA, 8'hFF);
    req_v_i = 1'b1; req_w_i = 1'b0; req_addr_i = 9'd7;
    tick();
    req_w_i = 1'b1; req_data_i = 64'hBB; req_mask_i = 8'hFF;
    tick();
    idle();
    checks++; if (resp_v_o !== 1'b1 || resp_data_o !== 64'hAA) begin failures++; $display("FAIL hazard_old: got v=%b d=%h expected v=1 d=aa", resp_v_o, resp_data_o); end
    pop();
    do_read(9'd7);
    tick();
    checks++; if (resp_v_o !== 1'b1 || resp_data_o !== 64'hBB) begin failures++; $display("FAIL hazard_new: got v=%b d=%h expected v=1 d=bb", resp_v_o, resp_data_o); end
    pop();
  endtask

  task automatic test_reset_mid();
    req_v_i = 1'b1; req_w_i = 1'b0; req_addr_i = 9'd3;
    tick();
    req_addr_i = 9'd7;
    tick();
    idle();
    tick();
    checks++; if (resp_v_o !== 1'b1 || resp_data_o !== sval(3) || req_ready_o !== 1'b0) begin
      failures++; $display("FAIL mid_full: got v=%b d=%h ready=%b expected v=1 d=%h ready=0", resp_v_o, resp_data_o, req_ready_o, sval(3)); end
    resp_yumi_i = 1'b1; req_v_i = 1'b1; req_addr_i = 9'd9;
    tick();
    resp_yumi_i = 1'b0;
    idle();
    reset_n_i = 1'b0;
    #1;
    checks++; if (resp_v_o !== 1'b0 || req_ready_o !== 1'b0 || mem_v_o !== 1'b0) begin
      failures++; $display("FAIL mid_rst: got v=%b ready=%b mem_v=%b expected 0 0 0", resp_v_o, req_ready_o, mem_v_o); end
    @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (resp_v_o !== 1'b0) begin failures++; $display("FAIL mid_stale c=%0d: got %b expected 0", c, resp_v_o); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
`ifdef HARD_MEM_CLEAR_ON_RESET_EN
    test_clear();
`endif
    test_write_read();
    test_mask();
    test_backpressure();
    test_streaming();
    test_hazard();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
